// File: rtl/nfu_pkg.sv
// Shared defaults and helpers for the NFU-2 accumulate tree.
// Used by nfu2_tree_pipe and nfu2_accum_tree (clamp only with NFU2_SATURATE_EN).
package nfu_pkg;
  localparam int NFU_N  = 16;
  localparam int NFU_TN = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Clamp a signed value into the n-bit two's complement range.
  function automatic longint sclamp(input longint v, input int n);
    longint hi, lo;
    hi = (longint'(1) << (n - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction
endpackage

// File: rtl/nfu2_accum_tree_if.sv
// Beat/result bus between NFU-1, the NFU-2 accumulate tree and NFU-3.
interface nfu2_accum_tree_if import nfu_pkg::*; #(
  parameter int N  = NFU_N,
  parameter int TN = NFU_TN
);
  logic                   i_valid;
  logic                   i_first;
  logic                   i_last;
  logic [TN-1:0][N-1:0]   i_vals;
  logic                   i_stall;
  logic                   o_valid;
  logic [N-1:0]           o_res;
  logic                   o_sat;

  modport master (output i_valid, i_first, i_last, i_vals, i_stall,
                  input  o_valid, o_res, o_sat);
  modport slave  (input  i_valid, i_first, i_last, i_vals, i_stall,
                  output o_valid, o_res, o_sat);
endinterface

// File: rtl/nfu2_tree_pipe.sv
// LOG_TN-stage registered pairwise adder tree with valid/first/last sideband.
// Each stage grows one bit, so the final sum is exact at N+LOG_TN bits.
module nfu2_tree_pipe import nfu_pkg::*; #(
  parameter  int N      = NFU_N,
  parameter  int TN     = NFU_TN,
  localparam int LOG_TN = clog2(TN)
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  valid,
  input  logic                  first,
  input  logic                  last,
  input  logic [TN-1:0][N-1:0]  vals,
  output logic                  sum_valid,
  output logic                  sum_first,
  output logic                  sum_last,
  output logic [N+LOG_TN-1:0]   sum
);
  for (genvar s = 0; s <= LOG_TN; s++) begin : stg
    localparam int W   = N + s;
    localparam int CNT = TN >> s;
    logic [CNT-1:0][W-1:0] d;
    logic vld, fst, lst;

    if (s == 0) begin : g_in
      // Sideband is qualified here so bubbles never carry first/last.
      assign d   = vals;
      assign vld = valid;
      assign fst = valid & first;
      assign lst = valid & last;
    end else begin : g_add
      logic [CNT-1:0][W-1:0] nxt;
      always_comb begin
        nxt = '0;
        for (int k = 0; k < CNT; k++)
          nxt[k] = {stg[s-1].d[2*k][W-2],   stg[s-1].d[2*k]} +
                   {stg[s-1].d[2*k+1][W-2], stg[s-1].d[2*k+1]};
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          d   <= '0;
          vld <= 1'b0;
          fst <= 1'b0;
          lst <= 1'b0;
        end else if (!stall) begin
          d   <= nxt;
          vld <= stg[s-1].vld;
          fst <= stg[s-1].fst;
          lst <= stg[s-1].lst;
        end
      end
    end
  end

  assign sum       = stg[LOG_TN].d[0];
  assign sum_valid = stg[LOG_TN].vld;
  assign sum_first = stg[LOG_TN].fst;
  assign sum_last  = stg[LOG_TN].lst;
endmodule

// File: rtl/nfu2_accum_tree.sv
// NFU-2 pipelined adder tree plus per-frame accumulator and result register.
// Define NFU2_SATURATE_EN to clamp results to N bits and report o_sat; default wraps.
module nfu2_accum_tree import nfu_pkg::*; #(
  parameter  int N      = NFU_N,
  parameter  int TN     = NFU_TN,
  parameter  int ACC_W  = 32,
  localparam int LOG_TN = clog2(TN)
)(
  input  logic              clk,
  input  logic              rst,
  nfu2_accum_tree_if.slave  bus
);
  localparam int SW = N + LOG_TN;

  logic [SW-1:0]    t_sum;
  logic             t_vld, t_fst, t_lst;
  logic [ACC_W-1:0] acc, acc_next, t_ext;
  logic [N-1:0]     res_next;
  logic             sat_next;

  nfu2_tree_pipe #(.N(N), .TN(TN)) u_tree (
    .clk       (clk),
    .rst       (rst),
    .stall     (bus.i_stall),
    .valid     (bus.i_valid),
    .first     (bus.i_first),
    .last      (bus.i_last),
    .vals      (bus.i_vals),
    .sum_valid (t_vld),
    .sum_first (t_fst),
    .sum_last  (t_lst),
    .sum       (t_sum)
  );

  // A first beat restarts from zero, silently dropping any open frame.
  assign t_ext    = ACC_W'($signed(t_sum));
  assign acc_next = (t_fst ? '0 : acc) + t_ext;

`ifdef NFU2_SATURATE_EN
  longint acc_s, clamped;
  always_comb begin
    acc_s    = longint'($signed(acc_next));
    clamped  = sclamp(acc_s, N);
    res_next = N'(clamped);
    sat_next = (clamped != acc_s);
  end
`else
  assign res_next = acc_next[N-1:0];
  assign sat_next = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc         <= '0;
      bus.o_valid <= 1'b0;
      bus.o_res   <= '0;
      bus.o_sat   <= 1'b0;
    end else if (!bus.i_stall) begin
      bus.o_valid <= t_vld & t_lst;
      if (t_vld) acc <= t_lst ? '0 : acc_next;
      if (t_vld & t_lst) begin
        bus.o_res <= res_next;
        bus.o_sat <= sat_next;
      end
    end
  end
endmodule
